pipelined_add4: RTL and testbench
=================================

// Module: pipelined_add4
// PURPOSE
//  - Two-stage pipelined adder tree. Sums four unsigned IN_W-bit operands into one IN_W+2-bit result.
//  - Datapath leaf block. It has no handshake: a new operand set is accepted on every clock edge
//    and one result is produced every cycle.
// PARAMETERS
//  - IN_W   default 14   operand width in bits (>=1)
//  - OUT_W  localparam = IN_W+2; result width; cannot be overridden
// PORTS
//  - clk    in   1       single clock; all state updates on rising edge
//  - rst    in   1       synchronous reset, active-high; sampled only on the rising edge of clk
//  - in1    in   IN_W    operand 1, unsigned
//  - in2    in   IN_W    operand 2, unsigned
//  - in3    in   IN_W    operand 3, unsigned
//  - in4    in   IN_W    operand 4, unsigned
//  - out    out  OUT_W   registered sum in1+in2+in3+in4
// BEHAVIOUR
//  - Stage 1 (edge k): s12 <= in1+in2 and s34 <= in3+in4. Each is an IN_W+1-bit register, zero-extended.
//  - Stage 2 (edge k+1): out <= s12+s34, at full OUT_W width.
//  - Latency: operands sampled at edge k appear on out after edge k+1 (2 cycles).
//  - Throughput: 1 result/cycle; operands may change every cycle.
//  - Width: OUT_W holds the maximum 4*(2^IN_W-1) exactly. No overflow or wrap is possible.
//    Never truncate an intermediate result.
//  - out is driven directly from a flop. It has no combinational path from the inputs.
//  - Reset: on any edge where rst=1, s12, s34 and out all load 0 (and in_q under INPUT_REG_EN).
//    out reads 0 after that edge.
//  - Reset mid-operation: in-flight sums are discarded. The first valid result appears 2 edges
//    (3 under INPUT_REG_EN) after the first edge with rst=0.
//  - Held reset: out stays 0 regardless of the inputs.
//  - Before the first reset, flop contents are don't-care. The bench must assert rst first.
//  - Operands are unsigned. There is no signed mode.
// CONFIGURATION
//  - Macro PIPELINED_ADD4_INPUT_REG_EN.
//  - Defined: add a stage 0 that registers in1..in4 into in_q1..in_q4 (reset to 0).
//    Stage 1 sums the registered copies. Latency = 3 cycles, throughput unchanged.
//  - Undefined: no input registers; latency = 2 cycles as above.
//  - Port list and widths are identical in both builds.
// TESTING
//  - Reset: rst=1 for 1 edge with all inputs 0 -> out=0. Hold rst=1 with inputs 5555 -> out stays 0.
//  - Steady: all inputs 1111 held -> out=4444 from the 2nd edge after rst drops.
//  - Back-to-back: all inputs 1111, 3333, 5555 on consecutive cycles -> out=4444, 13332, 22220
//    on consecutive cycles, 2 cycles later.
//  - Max: all inputs 16383 (IN_W=14) -> out=65532, no wrap.
//  - Mixed: in1=1, in2=0, in3=16383, in4=100 -> out=16484.
//    A distinct set the next cycle checks that no values mix between sets.
//  - Mid-op reset: while the 22220 stream is flowing, assert rst for 1 edge -> out=0 next edge.
//    22220 returns 2 edges after rst=0 (3 edges with PIPELINED_ADD4_INPUT_REG_EN).

Source files
------------

// File: rtl/pipelined_add4.sv
// -----------------------------------------------------------------------------
// pipelined_add4
//   Two-stage pipelined adder tree: out = in1 + in2 + in3 + in4 (unsigned).
//   A new operand set is accepted every clock and one result is produced per
//   cycle. Latency is 2 cycles, or 3 cycles when PIPELINED_ADD4_INPUT_REG_EN
//   is defined, which adds a register stage on the four operands.
//
// Configuration macro:
//   PIPELINED_ADD4_INPUT_REG_EN  - register in1..in4 before the adder tree.
//
// Ports:
//   clk      in   1        clock, all state updates on the rising edge
//   rst      in   1        synchronous active-high reset
//   in1..in4 in   IN_W     unsigned operands
//   out      out  IN_W+2   registered sum, wide enough that it never wraps
// -----------------------------------------------------------------------------
module pipelined_add4 #(
  parameter int unsigned IN_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in1,
  input  logic [IN_W-1:0]   in2,
  input  logic [IN_W-1:0]   in3,
  input  logic [IN_W-1:0]   in4,
  output logic [IN_W+1:0]   out
);

  localparam int unsigned SUM_W = IN_W + 1;
  localparam int unsigned OUT_W = IN_W + 2;

  // Operands as seen by the adder tree (raw inputs or their registered copies)
  logic [IN_W-1:0]  op1;
  logic [IN_W-1:0]  op2;
  logic [IN_W-1:0]  op3;
  logic [IN_W-1:0]  op4;

  // Stage-1 partial sums, one bit wider than an operand so no carry is lost
  logic [SUM_W-1:0] s12;
  logic [SUM_W-1:0] s34;

`ifdef PIPELINED_ADD4_INPUT_REG_EN
  logic [IN_W-1:0]  in_q1;
  logic [IN_W-1:0]  in_q2;
  logic [IN_W-1:0]  in_q3;
  logic [IN_W-1:0]  in_q4;

  // Stage 0: register the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q1 <= '0;
      in_q2 <= '0;
      in_q3 <= '0;
      in_q4 <= '0;
    end else begin
      in_q1 <= in1;
      in_q2 <= in2;
      in_q3 <= in3;
      in_q4 <= in4;
    end
  end

  assign op1 = in_q1;
  assign op2 = in_q2;
  assign op3 = in_q3;
  assign op4 = in_q4;
`else
  assign op1 = in1;
  assign op2 = in2;
  assign op3 = in3;
  assign op4 = in4;
`endif

  // Stage 1: pairwise sums, zero-extended before the add
  always_ff @(posedge clk) begin
    if (rst) begin
      s12 <= '0;
      s34 <= '0;
    end else begin
      s12 <= SUM_W'(op1) + SUM_W'(op2);
      s34 <= SUM_W'(op3) + SUM_W'(op4);
    end
  end

  // Stage 2: final sum at full output width, driven straight from the flop
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= OUT_W'(s12) + OUT_W'(s34);
    end
  end

endmodule

// File: tb/tb_pipelined_add4.sv
// -----------------------------------------------------------------------------
// tb_pipelined_add4
//   Self-checking bench for pipelined_add4. The reference model is a delay
//   line of expected sums: each clean edge pushes the arithmetic sum of the
//   operands presented, and a reset edge flushes the line to zeros.
// -----------------------------------------------------------------------------
module tb_pipelined_add4;

  localparam int unsigned IN_W  = 14;
  localparam int unsigned OUT_W = IN_W + 2;
`ifdef PIPELINED_ADD4_INPUT_REG_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic              clk;
  logic              rst;
  logic [IN_W-1:0]   in1;
  logic [IN_W-1:0]   in2;
  logic [IN_W-1:0]   in3;
  logic [IN_W-1:0]   in4;
  logic [OUT_W-1:0]  out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [OUT_W-1:0]  exp_out;
  logic [OUT_W-1:0]  pipe_q[$];

  pipelined_add4 #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand set for one rising edge and advance the reference model
  task automatic drive_edge(input int unsigned a, input int unsigned b,
                            input int unsigned c, input int unsigned d,
                            input logic r);
    @(negedge clk);
    in1 = IN_W'(a);
    in2 = IN_W'(b);
    in3 = IN_W'(c);
    in4 = IN_W'(d);
    rst = r;
    @(posedge clk);
    if (r) begin
      pipe_q.delete();
      for (int i = 0; i < int'(LAT) - 1; i++) pipe_q.push_back('0);
      exp_out = '0;
    end else begin
      pipe_q.push_back(OUT_W'(int'(IN_W'(a)) + int'(IN_W'(b)) +
                              int'(IN_W'(c)) + int'(IN_W'(d))));
      exp_out = pipe_q.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    drive_edge(0, 0, 0, 0, 1'b1);
    checks++;
    if (out !== '0) begin
      $display("FAIL reset_zero: out=%0d expected=0", out);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge(5555, 5555, 5555, 5555, 1'b1);
      checks++;
      if (out !== '0) begin
        $display("FAIL reset_held[%0d]: out=%0d expected=0", i, out);
        errors++;
      end
    end
  endtask

  task automatic test_steady();
    for (int i = 1; i <= int'(LAT) + 2; i++) begin
      drive_edge(1111, 1111, 1111, 1111, 1'b0);
      checks++;
      if (out !== exp_out) begin
        $display("FAIL steady_model[%0d]: out=%0d expected=%0d", i, out, exp_out);
        errors++;
      end
      checks++;
      if (i >= int'(LAT) && out !== OUT_W'(4444)) begin
        $display("FAIL steady_4444[%0d]: out=%0d expected=4444", i, out);
        errors++;
      end else if (i < int'(LAT) && out !== '0) begin
        $display("FAIL steady_flush[%0d]: out=%0d expected=0", i, out);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned vals[3] = '{1111, 3333, 5555};
    int unsigned want[3] = '{4444, 13332, 22220};
    int unsigned v;
    int k;
    for (int i = 0; i < 3 + int'(LAT) - 1; i++) begin
      v = vals[(i < 3) ? i : 2];
      drive_edge(v, v, v, v, 1'b0);
      checks++;
      if (out !== exp_out) begin
        $display("FAIL b2b_model[%0d]: out=%0d expected=%0d", i, out, exp_out);
        errors++;
      end
      k = i - (int'(LAT) - 1);
      if (k >= 0 && k < 3) begin
        checks++;
        if (out !== OUT_W'(want[k])) begin
          $display("FAIL b2b_value[%0d]: out=%0d expected=%0d", k, out, want[k]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    // Stream of 5555 is already flowing from the back-to-back test
    drive_edge(5555, 5555, 5555, 5555, 1'b1);
    checks++;
    if (out !== '0) begin
      $display("FAIL midrst_zero: out=%0d expected=0", out);
      errors++;
    end
    for (int i = 1; i <= int'(LAT); i++) begin
      drive_edge(5555, 5555, 5555, 5555, 1'b0);
      checks++;
      if (i < int'(LAT) && out !== '0) begin
        $display("FAIL midrst_flush[%0d]: out=%0d expected=0", i, out);
        errors++;
      end else if (i == int'(LAT) && out !== OUT_W'(22220)) begin
        $display("FAIL midrst_return: out=%0d expected=22220", out);
        errors++;
      end
    end
  endtask

  task automatic test_max_and_mixed();
    // Max set, mixed set, distinct follow-up set, then hold to drain
    int unsigned a[3] = '{16383, 1, 7};
    int unsigned b[3] = '{16383, 0, 8};
    int unsigned c[3] = '{16383, 16383, 9};
    int unsigned d[3] = '{16383, 100, 10};
    int unsigned want[3] = '{65532, 16484, 34};
    int k;
    for (int i = 0; i < 3 + int'(LAT) - 1; i++) begin
      k = (i < 3) ? i : 2;
      drive_edge(a[k], b[k], c[k], d[k], 1'b0);
      checks++;
      if (out !== exp_out) begin
        $display("FAIL maxmix_model[%0d]: out=%0d expected=%0d", i, out, exp_out);
        errors++;
      end
      k = i - (int'(LAT) - 1);
      if (k >= 0 && k < 3) begin
        checks++;
        if (out !== OUT_W'(want[k])) begin
          $display("FAIL maxmix_value[%0d]: out=%0d expected=%0d", k, out, want[k]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      drive_edge($urandom, $urandom, $urandom, $urandom, r);
      checks++;
      if (out !== exp_out) begin
        $display("FAIL random[%0d]: out=%0d expected=%0d", i, out, exp_out);
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    in4 = '0;
    exp_out = '0;
    test_reset();
    test_steady();
    test_back_to_back();
    test_midop_reset();
    test_max_and_mixed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
